// File: rtl/perf_cnt_pkg.sv
// ---------------------------------------------------------------
// perf_cnt_pkg: shared types and constants for the perf counter bank
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package perf_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  // Read-index width, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_CNT = 8;
  localparam int DEF_IDX_W   = idx_width(DEF_NUM_CNT);

  localparam int CYCLES     = 0;
  localparam int COMMITS    = 1;
  localparam int ICACHE_REQ = 2;
  localparam int ICACHE_HIT = 3;
  localparam int DCACHE_REQ = 4;
  localparam int DCACHE_HIT = 5;
  localparam int BR_MISS    = 6;
  localparam int STALL      = 7;

endpackage

`default_nettype wire

// File: rtl/perf_counter_cell.sv
// ---------------------------------------------------------------
// perf_counter_cell: one accumulator with sticky overflow bit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module perf_counter_cell
  import perf_cnt_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 2,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {{(CNT_WIDTH + 1 - INC_WIDTH){1'b0}}, inc_i};
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      // Carry out of the extended sum is the only overflow source.
      if (sum[CNT_WIDTH]) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
      end else begin
        cnt_d = sum[CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/perf_counter_bank.sv
// ---------------------------------------------------------------
// perf_counter_bank: run/freeze/clear event counter bank, indexed read port
// Optional shadow snapshot when PERF_CNT_SNAPSHOT_EN is defined. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module perf_counter_bank
  import perf_cnt_pkg::*;
#(
  parameter int NUM_CNT   = 8,
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 2,
  parameter int SATURATE  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic                           clear_i,
  input  logic                           snap_i,
  input  logic [NUM_CNT*INC_WIDTH-1:0]   evt_inc_i,
  input  logic                           rd_req_i,
  input  logic [idx_width(NUM_CNT)-1:0]  rd_idx_i,
  output logic                           rd_valid_o,
  output logic [CNT_WIDTH-1:0]           rd_data_o,
  output logic                           rd_ovf_o,
  output logic [NUM_CNT-1:0]             ovf_o,
  output logic                           running_o
);

  localparam int IDX_W = idx_width(NUM_CNT);

  state_e state_q, state_d;
  logic   running_q;
  logic   count_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (stop_i)  state_d = FROZEN;
      FROZEN:  if (start_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
    end
  end

  assign running_o = running_q;
  assign count_en  = (state_q == RUN) && !clear_i;

  logic [CNT_WIDTH-1:0] cnt_val [NUM_CNT];
  logic [NUM_CNT-1:0]   ovf_val;

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cell
      perf_counter_cell #(
        .CNT_WIDTH (CNT_WIDTH),
        .INC_WIDTH (INC_WIDTH),
        .SATURATE  (SATURATE)
      ) u_cell (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clear_i),
        .en_i  (count_en),
        .inc_i (evt_inc_i[gi*INC_WIDTH +: INC_WIDTH]),
        .cnt_o (cnt_val[gi]),
        .ovf_o (ovf_val[gi])
      );
    end
  endgenerate

  assign ovf_o = ovf_val;

  logic [CNT_WIDTH-1:0] src_cnt [NUM_CNT];
  logic [NUM_CNT-1:0]   src_ovf;

`ifdef PERF_CNT_SNAPSHOT_EN
  logic [CNT_WIDTH-1:0] shd_q [NUM_CNT];
  logic [NUM_CNT-1:0]   shd_ovf_q;

  // Shadows capture pre-update live values; clear beats snap.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int i = 0; i < NUM_CNT; i++) shd_q[i] <= '0;
      shd_ovf_q <= '0;
    end else if (snap_i) begin
      for (int i = 0; i < NUM_CNT; i++) shd_q[i] <= cnt_val[i];
      shd_ovf_q <= ovf_val;
    end
  end

  assign src_cnt = shd_q;
  assign src_ovf = shd_ovf_q;
`else
  logic unused_snap;
  assign unused_snap = snap_i;
  assign src_cnt     = cnt_val;
  assign src_ovf     = ovf_val;
`endif

  logic [CNT_WIDTH-1:0] rd_sel_data;
  logic                 rd_sel_ovf;

  // Out-of-range indices match no channel and fall through to zero.
  always_comb begin
    rd_sel_data = '0;
    rd_sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        rd_sel_data = src_cnt[i];
        rd_sel_ovf  = src_ovf[i];
      end
    end
  end

  logic                 rd_valid_q;
  logic [CNT_WIDTH-1:0] rd_data_q;
  logic                 rd_ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req_i;
      if (rd_req_i) begin
        rd_data_q <= rd_sel_data;
        rd_ovf_q  <= rd_sel_ovf;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_ovf_o   = rd_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_perf_counter_bank.sv
// ---------------------------------------------------------------
// tb_perf_counter_bank: directed self-checking bench for perf_counter_bank
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, stop_i = 1'b0, clear_i = 1'b0, snap_i = 1'b0;
  logic [15:0] evt_inc_i = '0;
  logic        rd_req_i = 1'b0;
  logic [2:0]  rd_idx_i = '0;

  logic        m_valid, m_rovf, m_run;
  logic [31:0] m_data;
  logic [7:0]  m_ovf;

  logic        s_valid, s_rovf, s_run;
  logic [3:0]  s_data;
  logic [5:0]  s_ovf;

  logic        w_valid, w_rovf, w_run;
  logic [3:0]  w_data;
  logic [5:0]  w_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter_bank u_main (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .snap_i(snap_i), .evt_inc_i(evt_inc_i), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(m_valid), .rd_data_o(m_data), .rd_ovf_o(m_rovf), .ovf_o(m_ovf),
    .running_o(m_run)
  );

  perf_counter_bank #(.NUM_CNT(6), .CNT_WIDTH(4), .INC_WIDTH(2), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .snap_i(snap_i), .evt_inc_i(evt_inc_i[11:0]), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(s_valid), .rd_data_o(s_data), .rd_ovf_o(s_rovf), .ovf_o(s_ovf),
    .running_o(s_run)
  );

  perf_counter_bank #(.NUM_CNT(6), .CNT_WIDTH(4), .INC_WIDTH(2), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .snap_i(snap_i), .evt_inc_i(evt_inc_i[11:0]), .rd_req_i(rd_req_i), .rd_idx_i(rd_idx_i),
    .rd_valid_o(w_valid), .rd_data_o(w_data), .rd_ovf_o(w_rovf), .ovf_o(w_ovf),
    .running_o(w_run)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_evt(input int ch, input logic [1:0] v);
    evt_inc_i = '0;
    evt_inc_i[ch*2 +: 2] = v;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  task automatic rd_raw(input int idx);
    rd_req_i = 1'b1; rd_idx_i = 3'(idx); tick(); rd_req_i = 1'b0;
  endtask

  // With shadows enabled, refresh them first so reads see live counts.
  task automatic rd(input int idx);
`ifdef PERF_CNT_SNAPSHOT_EN
    snap_i = 1'b1; tick(); snap_i = 1'b0;
`endif
    rd_raw(idx);
  endtask

  initial begin
    // reset
    ticks(2);
    rst = 1'b0;
    check("rst_running", m_run, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_ovf", m_ovf, 0);

    // basic count, stop cycle still counts
    pulse_start();
    check("run_after_start", m_run, 1);
    set_evt(0, 2'd1);
    ticks(9);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    evt_inc_i = '0;
    check("run_after_stop", m_run, 0);
    rd(0);
    check("rd1_valid", m_valid, 1);
    check("rd1_data", m_data, 10);
    check("rd1_rovf", m_rovf, 0);
    tick();
    check("rd1_valid_drop", m_valid, 0);
    check("rd1_data_hold", m_data, 10);

    // overflow: saturate vs wrap on 4-bit counters
    pulse_clear();
    check("clr_ovf_main", m_ovf, 0);
    pulse_start();
    set_evt(1, 2'd3);
    ticks(6);
    evt_inc_i = '0;
    pulse_stop();
    rd(1);
    check("ovf_main_data", m_data, 18);
    check("ovf_main_rovf", m_rovf, 0);
    check("ovf_sat_data", s_data, 15);
    check("ovf_sat_rovf", s_rovf, 1);
    check("ovf_wrap_data", w_data, 2);
    check("ovf_wrap_rovf", w_rovf, 1);
    check("ovf_sat_vec", s_ovf, 6'b000010);
    check("ovf_wrap_vec", w_ovf, 6'b000010);
    check("ovf_main_vec", m_ovf, 0);
    pulse_start();
    set_evt(1, 2'd1);
    tick();
    evt_inc_i = '0;
    pulse_stop();
    rd(1);
    check("sat_hold", s_data, 15);
    check("wrap_more", w_data, 3);
    check("main_more", m_data, 19);

    // freeze and resume
    pulse_clear();
    pulse_start();
    set_evt(2, 2'd2);
    ticks(2);
    pulse_stop();
    check("frz_running", m_run, 0);
    ticks(5);
    rd(2);
    check("frz_data", m_data, 6);
    check("frz_running2", m_run, 0);
    pulse_start();
    check("resume_running", m_run, 1);
    ticks(2);
    evt_inc_i = '0;
    pulse_stop();
    rd(2);
    check("resume_data", m_data, 10);
    check("resume_sat", s_data, 10);

    // out-of-range index on the 6-channel instance
    rd_raw(6);
    check("oor_valid", s_valid, 1);
    check("oor_data", s_data, 0);
    check("oor_rovf", s_rovf, 0);

    // clear with concurrent read returns pre-clear value
    pulse_clear();
    pulse_start();
    set_evt(0, 2'd1);
    ticks(5);
    evt_inc_i = '0;
`ifdef PERF_CNT_SNAPSHOT_EN
    snap_i = 1'b1; tick(); snap_i = 1'b0;
`endif
    set_evt(0, 2'd1);
    clear_i = 1'b1; rd_req_i = 1'b1; rd_idx_i = 3'd0;
    tick();
    clear_i = 1'b0; rd_req_i = 1'b0; evt_inc_i = '0;
    check("clrrd_data", m_data, 5);
    check("clrrd_running", m_run, 0);
    check("clrrd_ovf", m_ovf, 0);
    check("clrrd_sat_ovf", s_ovf, 0);
    rd(0);
    check("after_clr_data", m_data, 0);

    // back-to-back reads
    pulse_start();
    evt_inc_i = '0;
    evt_inc_i[1:0] = 2'd1;
    evt_inc_i[3:2] = 2'd2;
    evt_inc_i[5:4] = 2'd3;
    ticks(2);
    evt_inc_i = '0;
    pulse_stop();
`ifdef PERF_CNT_SNAPSHOT_EN
    snap_i = 1'b1; tick(); snap_i = 1'b0;
`endif
    rd_req_i = 1'b1;
    rd_idx_i = 3'd0; tick();
    check("b2b0_valid", m_valid, 1);
    check("b2b0_data", m_data, 2);
    rd_idx_i = 3'd1; tick();
    check("b2b1_valid", m_valid, 1);
    check("b2b1_data", m_data, 4);
    rd_idx_i = 3'd2; tick();
    check("b2b2_valid", m_valid, 1);
    check("b2b2_data", m_data, 6);
    rd_req_i = 1'b0; tick();
    check("b2b_end_valid", m_valid, 0);
    check("b2b_end_hold", m_data, 6);

    // command priorities
    pulse_start();
    check("prio_start_frozen", m_run, 1);
    pulse_start();
    check("prio_start_in_run", m_run, 1);
    start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
    check("prio_stop_start", m_run, 0);
    pulse_start();
    check("prio_resume", m_run, 1);
    clear_i = 1'b1; start_i = 1'b1; tick(); clear_i = 1'b0; start_i = 1'b0;
    check("prio_clear_start", m_run, 0);
    rd(0);
    check("prio_clear_zero", m_data, 0);
    pulse_stop();
    check("prio_stop_idle", m_run, 0);

    // snapshot behaviour (live value when shadows are absent)
    pulse_start();
    set_evt(0, 2'd1);
    ticks(7);
    snap_i = 1'b1; tick(); snap_i = 1'b0;
    ticks(3);
    evt_inc_i = '0;
    pulse_stop();
    rd_raw(0);
`ifdef PERF_CNT_SNAPSHOT_EN
    check("snap_data", m_data, 7);
`else
    check("snap_ignored", m_data, 11);
`endif
    snap_i = 1'b1; clear_i = 1'b1; tick(); snap_i = 1'b0; clear_i = 1'b0;
    rd_raw(0);
    check("snap_clear", m_data, 0);

    // reset beats start
    pulse_start();
    rst = 1'b1; start_i = 1'b1; rd_req_i = 1'b1; tick();
    rst = 1'b0; start_i = 1'b0; rd_req_i = 1'b0;
    check("rst_win_running", m_run, 0);
    check("rst_win_valid", m_valid, 0);
    check("rst_win_data", m_data, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Synthesizable, parametrised bank of NUM_CNT event counters that replaces ad-hoc bench-side cycle, commit, hit and stall counters.
- Each channel accumulates a multi-bit per-cycle increment, so a multi-issue commit or a multi-port cache can report more than one event per cycle.
- Counting is controlled by a run/freeze/clear state machine, and counters are read through a one-cycle-latency indexed read port.
- Sits beside the CPU/cache hierarchy; event strobes come from datapath and cache control, reads go to the bench or a debug/CSR path.

Parameters:
- NUM_CNT, 8, number of counter channels (>=1).
- CNT_WIDTH, 32, width of each counter in bits (>=2).
- INC_WIDTH, 2, width of the per-channel per-cycle increment; max increment is 2^INC_WIDTH-1.
- SATURATE, 1, 1 = counter holds at all-ones on overflow; 0 = counter wraps modulo 2^CNT_WIDTH.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; enter or resume counting.
- stop  in  1  pulse; freeze counting.
- clear  in  1  pulse; zero all counters and overflow flags.
- snap  in  1  pulse; capture snapshot (used only with PERF_CNT_SNAPSHOT_EN).
- evt_inc  in  NUM_CNT*INC_WIDTH  per-channel increment; channel i occupies bits [i*INC_WIDTH +: INC_WIDTH].
- rd_req  in  1  read request.
- rd_idx  in  $clog2(NUM_CNT) (min 1)  channel to read.
- rd_valid  out  1  read data valid.
- rd_data  out  CNT_WIDTH  read counter value.
- rd_ovf  out  1  overflow flag of the read channel.
- ovf  out  NUM_CNT  sticky per-channel overflow flags.
- running  out  1  high while state is RUN.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; all counters 0, ovf 0.
  - rd_valid 0, rd_data 0, rd_ovf 0, running 0.
  - Reset wins over every other input.
- States:
  - IDLE: start -> RUN.
  - RUN: stop -> FROZEN.
  - FROZEN: start -> RUN, and counters resume from their held values.
  - clear in any state -> IDLE, with counters and ovf zeroed.
- Priority when asserted in the same cycle: rst > clear > stop > start.
  - clear+start: go to IDLE with zeroed counters; start is dropped.
  - stop+start in RUN: go to FROZEN.
  - start in RUN and stop in IDLE/FROZEN are no-ops.
- running is a registered output equal to (state==RUN).
- Counting:
  - At every edge where the current state is RUN and clear=0: cnt[i] <= cnt[i] + evt_inc[i].
  - The stop cycle still counts; the start cycle does not, so the first counted cycle is the one after start.
- Arithmetic:
  - Compute the sum in CNT_WIDTH+1 bits; a carry-out sets ovf[i] (sticky until clear or rst).
  - SATURATE=1: result is all-ones; further increments keep it at all-ones.
  - SATURATE=0: result is the low CNT_WIDTH bits.
  - evt_inc=0 never sets ovf.
- Read port:
  - rd_req at edge t gives rd_valid=1 for exactly one cycle after t.
  - rd_data/rd_ovf are the values held in the registers before edge t's update, so increments and clear at edge t are not visible.
  - Back-to-back requests give back-to-back valid cycles.
  - rd_idx>=NUM_CNT returns rd_data=0, rd_ovf=0, with rd_valid still asserted.
  - With no request: rd_valid=0 and rd_data/rd_ovf hold their last values.
- Read during clear returns the pre-clear value.

Optional Feature:
- Macro: PERF_CNT_SNAPSHOT_EN.
- Defined:
  - Adds NUM_CNT shadow registers plus shadow overflow bits.
  - snap=1 at an edge copies the live counters (pre-update values) into the shadows.
  - The read port returns shadow values.
  - clear and rst zero the shadows.
  - snap and clear in the same cycle: clear wins and the shadows are zeroed.
- Undefined:
  - snap is ignored; reads return live counters.
  - No shadow storage is synthesized.

Decomposition:
- Shared package perf_cnt_pkg holds:
  - the state enum (IDLE, RUN, FROZEN);
  - the localparam for the index width;
  - channel-index constants for standard events: CYCLES=0, COMMITS=1, ICACHE_REQ=2, ICACHE_HIT=3, DCACHE_REQ=4, DCACHE_HIT=5, BR_MISS=6, STALL=7.
- One sub-module, perf_counter_cell: a single saturating/wrapping accumulator with a sticky overflow bit, instantiated NUM_CNT times via generate.
- The state machine and read mux stay in the top module.

Test Plan:
- Reset then start, evt_inc ch0=1 for 10 cycles, then stop; read idx0 -> rd_valid one cycle later, rd_data=10, ovf=0.
- CNT_WIDTH=4, SATURATE=1, ch1 inc=3 for 6 cycles -> counter 15 and ovf[1]=1; same stimulus with SATURATE=0 -> counter 2 (18 mod 16) and ovf[1]=1.
- start, count ch2 inc=2 for 3 cycles (value 6), stop, drive inc=2 for 5 more cycles, then start and count 2 more cycles -> read gives 10; running low while frozen.
- Count to 5, then assert clear and rd_req idx0 in the same cycle -> rd_data=5; a read in the next cycle -> 0; state IDLE, ovf all 0.
- Read rd_idx=NUM_CNT (out of range) -> rd_valid=1, rd_data=0; three consecutive rd_req on idx 0,1,2 -> three consecutive valid beats in order.
- With PERF_CNT_SNAPSHOT_EN defined: count to 7, snap, count 4 more cycles -> read returns 7; assert snap+clear together -> read returns 0.
